// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - serializes debounced buttons into PRESS/LONG/REPEAT/RELEASE events
// One button owns the controller from its rising edge until it is released.
module button_event_ctrl #(
  parameter int NUM_BTN      = 4,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  localparam int ID_W = $clog2(NUM_BTN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_fast,
  input  logic [NUM_BTN-1:0] btn_deb,
  output logic               evt_valid,
  output logic [ID_W-1:0]    evt_id,
  output logic [1:0]         evt_kind,
  output logic               busy
);
  localparam int CNT_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

  localparam logic [1:0] KIND_PRESS   = 2'b00;
  localparam logic [1:0] KIND_LONG    = 2'b01;
  localparam logic [1:0] KIND_REPEAT  = 2'b10;
  localparam logic [1:0] KIND_RELEASE = 2'b11;

  typedef enum logic [1:0] {IDLE, HELD, RPT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [NUM_BTN-1:0] prev_q, prev_d;
  logic               evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]    evt_id_q, evt_id_d;
  logic [1:0]         evt_kind_q, evt_kind_d;
  logic               busy_q, busy_d;

  logic [NUM_BTN-1:0] rise;
  logic [ID_W-1:0]    first_idx;

  always_comb begin
    rise      = btn_deb & ~prev_q;
    first_idx = '0;
    // Scan downwards so the lowest rising index wins.
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (rise[i]) first_idx = ID_W'(i);
    end

    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    prev_d      = btn_deb;
    evt_valid_d = 1'b0;
    evt_id_d    = evt_id_q;
    evt_kind_d  = evt_kind_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (|rise) begin
          owner_d     = first_idx;
          evt_valid_d = 1'b1;
          evt_kind_d  = KIND_PRESS;
          evt_id_d    = first_idx;
          cnt_d       = '0;
          state_d     = HELD;
          busy_d      = 1'b1;
        end
      end
      HELD, RPT: begin
        // Release is checked first so it beats a completing tick.
        if (!btn_deb[owner_q]) begin
          evt_valid_d = 1'b1;
          evt_kind_d  = KIND_RELEASE;
          evt_id_d    = owner_q;
          state_d     = IDLE;
          busy_d      = 1'b0;
        end else if (tick_fast) begin
          if (cnt_q == ((state_q == HELD) ? LONG_LAST : REPEAT_LAST)) begin
            evt_valid_d = 1'b1;
            evt_kind_d  = (state_q == HELD) ? KIND_LONG : KIND_REPEAT;
            evt_id_d    = owner_q;
            cnt_d       = '0;
            state_d     = RPT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= '0;
      prev_q      <= '1;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_kind_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      prev_q      <= prev_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_kind_q  <= evt_kind_d;
      busy_q      <= busy_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_kind  = evt_kind_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_button_event_ctrl.sv
// tb/tb_button_event_ctrl.sv - scoreboard bench for button_event_ctrl
// Driver steps a tick-count reference model; monitor pops expectations per clock.
module tb_button_event_ctrl;
  localparam int NB = 4;
  localparam int LT = 3;
  localparam int RT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick_fast = 1'b0;
  logic [NB-1:0] btn_deb = '0;
  logic          evt_valid;
  logic [1:0]    evt_id;
  logic [1:0]    evt_kind;
  logic          busy;

  button_event_ctrl #(.NUM_BTN(NB), .LONG_TICKS(LT), .REPEAT_TICKS(RT)) dut (
    .clk(clk), .rst(rst), .tick_fast(tick_fast), .btn_deb(btn_deb),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_kind(evt_kind), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int tag; logic [1:0] kind; logic [1:0] id; } ev_t;
  typedef struct { int tag; logic busy; } bz_t;
  ev_t eq[$];
  bz_t bq[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: counts ticks seen while the owner is held since PRESS.
  int          m_tag = 0;
  int          m_phase = 0;
  bit          m_owned;
  int          m_owner;
  int          m_ticks;
  logic [NB-1:0] m_prev;

  task automatic model_reset();
    m_owned = 0; m_owner = 0; m_ticks = 0; m_prev = '1;
    eq.delete(); bq.delete();
  endtask

  task automatic push_ev(input logic [1:0] kind, input int id);
    ev_t e;
    e.tag = m_tag; e.kind = kind; e.id = 2'(id);
    eq.push_back(e);
  endtask

  // Called at a negedge: drive inputs, predict, then wait to the next negedge.
  task automatic step(input logic [NB-1:0] b, input bit t);
    logic [NB-1:0] r;
    bz_t z;
    btn_deb = b; tick_fast = t;
    r = b & ~m_prev;
    m_prev = b;
    if (!m_owned) begin
      if (r != 0) begin
        for (int i = NB - 1; i >= 0; i--) if (r[i]) m_owner = i;
        m_owned = 1; m_ticks = 0;
        push_ev(2'b00, m_owner);
      end
    end else if (!b[m_owner]) begin
      m_owned = 0;
      push_ev(2'b11, m_owner);
    end else if (t) begin
      m_ticks++;
      if (m_ticks == LT) push_ev(2'b01, m_owner);
      else if (m_ticks > LT && (m_ticks - LT) % RT == 0) push_ev(2'b10, m_owner);
    end
    z.tag = m_tag; z.busy = m_owned;
    bq.push_back(z);
    m_tag++;
    @(negedge clk);
  endtask

  task automatic step_auto(input logic [NB-1:0] b);
    step(b, (m_phase % 4) == 3);
    m_phase++;
  endtask

  task automatic do_reset_mid();
    rst = 1'b1;
    #1;
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_id", evt_id, 0);
    chk("rst_evt_kind", evt_kind, 0);
    chk("rst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: sampled 2 time units after the active edge.
  bit         open = 0;
  logic [1:0] open_id = '0;
  always @(posedge clk) begin
    bz_t b;
    ev_t e;
    #2;
    if (rst) begin
      open = 0;
    end else if (bq.size() == 0) begin
      chk("unexpected_output_cycle", evt_valid, 0);
    end else begin
      b = bq.pop_front();
      chk("busy", busy, b.busy);
      if (eq.size() > 0 && eq[0].tag == b.tag) begin
        e = eq.pop_front();
        chk("evt_valid", evt_valid, 1);
        if (evt_valid) begin
          chk("evt_kind", evt_kind, e.kind);
          chk("evt_id", evt_id, e.id);
        end
      end else begin
        chk("evt_valid_idle", evt_valid, 0);
      end
      if (evt_valid) begin
        if (evt_kind == 2'b00) begin
          chk("bracket_press_while_open", open, 0);
          open = 1; open_id = evt_id;
        end else begin
          chk("bracket_event_without_press", open, 1);
          chk("bracket_id", evt_id, open_id);
          if (evt_kind == 2'b11) open = 0;
        end
      end
    end
  end

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("init_evt_valid", evt_valid, 0);
    chk("init_busy", busy, 0);
    chk("init_evt_kind", evt_kind, 0);
    rst = 1'b0;

    // Tap on btn1: short hold, no LONG.
    for (int i = 0; i < 2; i++) step_auto(4'b0000);
    for (int i = 0; i < 5; i++) step(4'b0010, 0);
    for (int i = 0; i < 3; i++) step_auto(4'b0000);

    // Long hold of btn2.
    m_phase = 0;
    for (int i = 0; i < 20; i++) step_auto(4'b0100);
    for (int i = 0; i < 3; i++) step_auto(4'b0000);

    // Collision: btn0 and btn3 together, btn3 re-edges while btn0 owns.
    step_auto(4'b1001);
    step_auto(4'b1001);
    step_auto(4'b0001);
    step_auto(4'b1001);
    step_auto(4'b1001);
    for (int i = 0; i < 4; i++) step_auto(4'b1000);
    step_auto(4'b0000);
    step_auto(4'b1000);
    step_auto(4'b0000);
    step_auto(4'b0000);

    // Tie: owner released on the completing third tick.
    step(4'b0010, 0);
    step(4'b0010, 1);
    step(4'b0010, 1);
    step(4'b0010, 0);
    step(4'b0000, 1);
    step(4'b0000, 0);

    // Reset while held, then hold through reset and re-press.
    for (int i = 0; i < 6; i++) step_auto(4'b0100);
    btn_deb = 4'b0100;
    do_reset_mid();
    for (int i = 0; i < 5; i++) step_auto(4'b0100);
    step_auto(4'b0000);
    for (int i = 0; i < 3; i++) step_auto(4'b0100);
    step_auto(4'b0000);
    step_auto(4'b0000);

    // Random stream.
    begin
      logic [NB-1:0] b;
      b = '0;
      for (int i = 0; i < 3000; i++) begin
        for (int k = 0; k < NB; k++) if ($urandom_range(0, 9) == 0) b[k] = ~b[k];
        step(b, $urandom_range(0, 2) == 0);
      end
      step(4'b0000, 0);
      step(4'b0000, 0);
    end

    #3;
    chk("queue_drained_events", eq.size(), 0);
    chk("queue_drained_busy", bq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
